// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS-32 control unit: ID decode carried through ID/EX, EX/MEM and MEM/WB,
// with load-use stall, multi-cycle branch flush and jump flush. Optional: PIPE_CTRL_ILLEGAL_TRAP_EN.
module pipe_ctrl_unit #(
    parameter int unsigned OPC_W        = 6,
    parameter int unsigned RA_W         = 5,
    parameter int unsigned ALUOP_W      = 2,
    parameter int unsigned BR_FLUSH_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode_i,
    input  logic [RA_W-1:0]    rs_i,
    input  logic [RA_W-1:0]    rt_i,
    input  logic               branch_cond_i,
    output logic               pc_write_o,
    output logic               ifid_write_o,
    output logic               ifid_flush_o,
    output logic               jump_o,
    output logic               ex_reg_dst_o,
    output logic               ex_alu_src_o,
    output logic [ALUOP_W-1:0] ex_alu_op_o,
    output logic [RA_W-1:0]    ex_rt_o,
    output logic               br_taken_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               wb_reg_write_o,
    output logic               wb_mem_to_reg_o,
    output logic               illegal_o
);

    localparam int unsigned CNT_W = $clog2(BR_FLUSH_CYC + 1);

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(35);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(43);

    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic               mem_to_reg;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               branch_ne;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    typedef enum logic [0:0] {RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            dec;
    ctrl_t            ex_q, ex_d;
    logic [RA_W-1:0]  ex_rt_q, ex_rt_d;
    logic             uses_rt;
    logic             is_jump;
    logic             dec_illegal;
    logic             stall;
    logic             bubble;
    logic             illegal_set;
    logic             mem_read_q, mem_write_q, mem_reg_write_q, mem_mem_to_reg_q;
    logic             wb_reg_write_q, wb_mem_to_reg_q;

    // ID-stage opcode decode
    always_comb begin
        dec         = '0;
        uses_rt     = 1'b0;
        is_jump     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALUOP_W'(2);
                uses_rt       = 1'b1;
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALUOP_W'(1);
                uses_rt    = 1'b1;
            end
            OP_BNE: begin
                dec.branch    = 1'b1;
                dec.branch_ne = 1'b1;
                dec.alu_op    = ALUOP_W'(1);
                uses_rt       = 1'b1;
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_J:    is_jump     = 1'b1;
            default: dec_illegal = 1'b1;
        endcase
    end

    assign br_taken_o = ex_q.branch & (branch_cond_i ^ ex_q.branch_ne);
    assign stall      = ex_q.mem_read & ((ex_rt_q == rs_i) | (uses_rt & (ex_rt_q == rt_i)));

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
`endif

    // Flush FSM next state and hazard outputs; branch beats stall beats jump
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bubble       = 1'b0;
        ifid_flush_o = 1'b0;
        jump_o       = 1'b0;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        illegal_set  = 1'b0;
        case (state_q)
            RUN: begin
                if (br_taken_o) begin
                    ifid_flush_o = 1'b1;
                    bubble       = 1'b1;
                    cnt_d        = CNT_W'(BR_FLUSH_CYC - 1);
                    if (cnt_d != '0) state_d = FLUSH;
                end else if (stall) begin
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    bubble       = 1'b1;
                end else if (is_jump) begin
                    jump_o       = 1'b1;
                    ifid_flush_o = 1'b1;
                    bubble       = 1'b1;
                end else if (dec_illegal) begin
                    illegal_set = 1'b1;
                end
            end
            FLUSH: begin
                bubble       = 1'b1;
                ifid_flush_o = 1'b1;
                cnt_d        = CNT_W'(cnt_q - CNT_W'(1));
                if (cnt_q == CNT_W'(1)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
        if (illegal_set || illegal_q) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end
`endif
    end

    assign ex_d    = bubble ? ctrl_t'('0) : dec;
    assign ex_rt_d = bubble ? '0 : rt_i;

    // Pipeline control registers and FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            cnt_q            <= '0;
            ex_q             <= '0;
            ex_rt_q          <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            ex_q             <= ex_d;
            ex_rt_q          <= ex_rt_d;
            mem_read_q       <= ex_q.mem_read;
            mem_write_q      <= ex_q.mem_write;
            mem_reg_write_q  <= ex_q.reg_write;
            mem_mem_to_reg_q <= ex_q.mem_to_reg;
            wb_reg_write_q   <= mem_reg_write_q;
            wb_mem_to_reg_q  <= mem_mem_to_reg_q;
        end
    end

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    // Sticky trap: only reset releases the frozen front end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else if (illegal_set) illegal_q <= 1'b1;
    end
    assign illegal_o = illegal_q | illegal_set;
`else
    assign illegal_o = illegal_set;
`endif

    assign ex_reg_dst_o    = ex_q.reg_dst;
    assign ex_alu_src_o    = ex_q.alu_src;
    assign ex_alu_op_o     = ex_q.alu_op;
    assign ex_rt_o         = ex_rt_q;
    assign mem_read_o      = mem_read_q;
    assign mem_write_o     = mem_write_q;
    assign wb_reg_write_o  = wb_reg_write_q;
    assign wb_mem_to_reg_o = wb_mem_to_reg_q;

endmodule
